// File: rtl/gcd_arb_pkg.sv
// Shared types and defaults for the GCD request arbiter.
package gcd_arb_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned NREQ_MAX  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/gcd_arb_rr_pick.sv
// rr_pick: combinational round-robin selector; one-hot grant of the first request at or after ptr.
module rr_pick
   import gcd_arb_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             any
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      any   = |req;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = PTR_W'((32'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcd_request_arbiter.sv
// gcd_request_arbiter: round-robin front end sharing one GCD core among NREQ clients.
// Define GCD_ARB_TIMEOUT_EN to add a watchdog on the core handshake and the rsp_err port.
module gcd_request_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_gcd,
   output logic                  busy,
   output logic                  gcd_start,
   output logic [WIDTH-1:0]      gcd_a,
   output logic [WIDTH-1:0]      gcd_b,
   input  logic                  gcd_done,
`ifdef GCD_ARB_TIMEOUT_EN
   output logic                  rsp_err,
`endif
   input  logic [WIDTH-1:0]      gcd_result
);

   localparam int unsigned PTR_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 1) begin : g_param_chk
      $error("gcd_request_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   state_e           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [NREQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
   logic             busy_q, busy_d, start_q, start_d;

   logic [NREQ-1:0]  grant;
   logic             any_req;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [PTR_W-1:0] sel_idx;

`ifdef GCD_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d, rsp_err_q, rsp_err_d;
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .any   (any_req)
   );

   // Operand mux driven by the one-hot grant
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a   = req_a[i*WIDTH +: WIDTH];
            sel_b   = req_b[i*WIDTH +: WIDTH];
            sel_idx = PTR_W'(i);
         end
      end
   end

   // Handshake pulses appear the cycle after the state that decides them; gcd_start lines up with LAUNCH.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_gcd_d   = '0;
      start_d     = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
      rsp_err_d   = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               req_ready_d = grant;
               owner_d     = sel_idx;
               a_d         = sel_a;
               b_d         = sel_b;
`ifdef GCD_ARB_TIMEOUT_EN
               err_d       = 1'b0;
`endif
               // gcd(0,x) = x needs no core run
               if (sel_a == '0 || sel_b == '0) begin
                  res_d   = sel_a | sel_b;
                  state_d = ST_RESP;
               end else begin
                  start_d = 1'b1;
                  state_d = ST_LAUNCH;
`ifdef GCD_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (gcd_done) begin
               res_d   = gcd_result;
               state_d = ST_RESP;
            end
`ifdef GCD_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            rsp_valid_d[owner_q] = 1'b1;
            rsp_gcd_d            = res_q;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err_d            = err_q;
`endif
            if (32'(owner_q) == NREQ - 1) ptr_d = '0;
            else                          ptr_d = owner_q + PTR_W'(1);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_gcd_q   <= '0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_gcd_q   <= rsp_gcd_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
`ifdef GCD_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_gcd   = rsp_gcd_q;
   assign busy      = busy_q;
   assign gcd_start = start_q;
   assign gcd_a     = a_q;
   assign gcd_b     = b_q;
`ifdef GCD_ARB_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_gcd_request_arbiter.sv
// Bench for gcd_request_arbiter with a behavioural subtractive GCD core and a Euclid/round-robin reference.
// Define GCD_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_gcd_request_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 8;
   localparam int NJOB    = 60;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ-1:0]       req_ready, rsp_valid;
   logic [WIDTH-1:0]      rsp_gcd, gcd_a, gcd_b, core_res;
   logic                  busy, gcd_start, core_done, core_run, mute, hold_mode;
   logic [WIDTH-1:0]      cx, cy;
`ifdef GCD_ARB_TIMEOUT_EN
   logic                  rsp_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int multi_ready = 0;
   int multi_rsp = 0;
   int g_idx[$], g_mask[$], g_cyc[$], g_exp[$], g_ea[$], g_eb[$], g_oa[$], g_ob[$];
   int r_idx[$], r_val[$], r_err[$], r_cyc[$], st_cyc[$];

   always #5 clk = ~clk;

   gcd_request_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_gcd    (rsp_gcd),
      .busy       (busy),
      .gcd_start  (gcd_start),
      .gcd_a      (gcd_a),
      .gcd_b      (gcd_b),
      .gcd_done   (core_done & ~mute),
`ifdef GCD_ARB_TIMEOUT_EN
      .rsp_err    (rsp_err),
`endif
      .gcd_result (core_res)
   );

   // Subtractive GCD core: done is a level held until the next start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cx <= '0; cy <= '0; core_run <= 1'b0; core_done <= 1'b0; core_res <= '0;
      end else if (gcd_start) begin
         cx <= gcd_a; cy <= gcd_b; core_run <= 1'b1; core_done <= 1'b0;
      end else if (core_run) begin
         if (cx == cy) begin
            core_done <= 1'b1; core_res <= cx; core_run <= 1'b0;
         end else if (cx > cy) cx <= cx - cy;
         else                  cy <= cy - cx;
      end
   end

   function automatic int ref_gcd(input int unsigned a, input int unsigned b);
      int unsigned x, y, t;
      x = a; y = b;
      while (y != 0) begin t = x % y; x = y; y = t; end
      return int'(x);
   endfunction

   function automatic int model_pick(input int mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic clear_log();
      g_idx.delete(); g_mask.delete(); g_cyc.delete(); g_exp.delete();
      g_ea.delete(); g_eb.delete(); g_oa.delete(); g_ob.delete();
      r_idx.delete(); r_val.delete(); r_err.delete(); r_cyc.delete(); st_cyc.delete();
      cyc = 0; multi_ready = 0; multi_rsp = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; hold_mode = 1'b0; mute = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_log();
   endtask

   task automatic set_op(input int i, input int unsigned a, input int unsigned b);
      req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   // One clock: record what the DUT shows and let accepted requesters drop valid
   task automatic step();
      logic [NREQ-1:0] vmask;
      logic            e;
      vmask = req_valid;
      @(posedge clk);
      #1;
      cyc++;
`ifdef GCD_ARB_TIMEOUT_EN
      e = rsp_err;
`else
      e = 1'b0;
`endif
      if ($countones(req_ready) > 1) multi_ready++;
      if ($countones(rsp_valid) > 1) multi_rsp++;
      if (gcd_start) st_cyc.push_back(cyc);
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            g_idx.push_back(i); g_mask.push_back(int'(vmask)); g_cyc.push_back(cyc);
            g_exp.push_back(ref_gcd(32'(req_a[i*WIDTH +: WIDTH]), 32'(req_b[i*WIDTH +: WIDTH])));
            g_ea.push_back(int'(req_a[i*WIDTH +: WIDTH])); g_eb.push_back(int'(req_b[i*WIDTH +: WIDTH]));
            g_oa.push_back(int'(gcd_a)); g_ob.push_back(int'(gcd_b));
            if (!hold_mode) req_valid[i] = 1'b0;
         end
         if (rsp_valid[i]) begin
            r_idx.push_back(i); r_val.push_back(int'(rsp_gcd)); r_err.push_back(int'(e)); r_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic run_until(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (r_idx.size() < n && k < budget) begin step(); k++; end
      ok = (r_idx.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; mute = 1'b0; hold_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({busy, gcd_start} !== 2'b00) begin errors++; $display("FAIL reset_busy_start: got %b want 00", {busy, gcd_start}); end
      checks++; if ({req_ready, rsp_valid} !== '0) begin errors++; $display("FAIL reset_handshake: got %b want 0", {req_ready, rsp_valid}); end
      checks++; if ({rsp_gcd, gcd_a, gcd_b} !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", {rsp_gcd, gcd_a, gcd_b}); end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      set_op(0, 100, 15); req_valid[0] = 1'b1;
      run_until(1, 2000, ok);
      repeat (3) step();
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no response, want 1"); end
      checks++; if (g_idx.size() != 1 || g_idx[0] != 0) begin errors++; $display("FAIL single_grant: got %0d grants, want 1 to req0", g_idx.size()); end
      checks++; if (st_cyc.size() != 1) begin errors++; $display("FAIL single_start: got %0d starts want 1", st_cyc.size()); end
      checks++; if (r_idx.size() != 1 || r_idx[0] != 0 || r_val[0] != 5) begin errors++; $display("FAIL single_rsp: got %0d rsps val %0d want 1 rsp to req0 val 5", r_idx.size(), ok ? r_val[0] : -1); end
      checks++; if (gcd_a !== 16'd100 || gcd_b !== 16'd15 || busy !== 1'b0) begin errors++; $display("FAIL single_hold: got a=%0d b=%0d busy=%b want 100 15 0", gcd_a, gcd_b, busy); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      set_op(0, 30, 20); set_op(2, 27, 174); req_valid = 4'b0101;
      run_until(2, 2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL simul_timeout: got %0d rsps want 2", r_idx.size()); end
      checks++; if (ok && (g_idx[0] != 0 || g_idx[1] != 2)) begin errors++; $display("FAIL simul_order: got %0d,%0d want 0,2", g_idx[0], g_idx[1]); end
      checks++; if (ok && (r_idx[0] != 0 || r_val[0] != 10 || r_idx[1] != 2 || r_val[1] != 3)) begin errors++; $display("FAIL simul_rsp: got %0d:%0d %0d:%0d want 0:10 2:3", r_idx[0], r_val[0], r_idx[1], r_val[1]); end
      // pointer now at 3: req3 must win over req1
      set_op(1, 12, 18); set_op(3, 49, 21); req_valid = 4'b1010;
      run_until(4, 2000, ok);
      checks++; if (!ok || g_idx[2] != 3 || g_idx[3] != 1) begin errors++; $display("FAIL simul_ptr: got %0d,%0d want 3,1", g_idx[2], g_idx[3]); end
      checks++; if (ok && (r_val[2] != 7 || r_val[3] != 6 || multi_ready != 0)) begin errors++; $display("FAIL simul_rsp2: got %0d,%0d multi %0d want 7,6 multi 0", r_val[2], r_val[3], multi_ready); end
   endtask

   task automatic test_zero_bypass();
      bit ok;
      do_reset();
      set_op(1, 0, 174); req_valid[1] = 1'b1;
      run_until(1, 50, ok);
      repeat (2) step();
      checks++; if (!ok || r_idx[0] != 1 || r_val[0] != 174) begin errors++; $display("FAIL zero_rsp: got idx %0d val %0d want 1 174", r_idx[0], r_val[0]); end
      checks++; if (st_cyc.size() != 0) begin errors++; $display("FAIL zero_start: got %0d starts want 0", st_cyc.size()); end
      checks++; if (ok && r_cyc[0] - g_cyc[0] != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", r_cyc[0] - g_cyc[0]); end
   endtask

   task automatic test_all_hold();
      bit ok;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 50, 25);
      hold_mode = 1'b1; req_valid = '1;
      run_until(5, 2000, ok);
      req_valid = '0; hold_mode = 1'b0;
      repeat (4) step();
      checks++; if (!ok || g_idx.size() != 5) begin errors++; $display("FAIL hold_count: got %0d grants want 5", g_idx.size()); end
      for (int k = 0; k < 5 && k < r_idx.size(); k++) begin
         checks++;
         if (g_idx[k] != exp_order[k] || r_idx[k] != exp_order[k] || r_val[k] != 25) begin
            errors++; $display("FAIL hold_grant%0d: got req%0d rsp%0d val %0d want req%0d val 25", k, g_idx[k], r_idx[k], r_val[k], exp_order[k]);
         end
      end
      checks++; if (multi_ready != 0 || multi_rsp != 0) begin errors++; $display("FAIL hold_onehot: got %0d/%0d multi-hot want 0/0", multi_ready, multi_rsp); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k;
      do_reset();
      set_op(0, 100, 15); req_valid[0] = 1'b1;
      k = 0;
      while (st_cyc.size() == 0 && k < 20) begin step(); k++; end
      repeat (2) step();
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== '0 || gcd_a !== '0 || gcd_start !== 1'b0) begin errors++; $display("FAIL midrst_clear: got busy %b rsp %b a %0d want 0", busy, rsp_valid, gcd_a); end
      repeat (2) step();
      rst = 1'b0;
      repeat (20) step();
      checks++; if (r_idx.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_norsp: got %0d rsps busy %b want 0 0", r_idx.size(), busy); end
      set_op(3, 50, 25); req_valid[3] = 1'b1;
      run_until(1, 500, ok);
      checks++; if (!ok || r_idx[0] != 3 || r_val[0] != 25) begin errors++; $display("FAIL midrst_next: got idx %0d val %0d want 3 25", r_idx[0], r_val[0]); end
   endtask

   task automatic test_random();
      int launched, k, mptr, nstart, exp;
      int unsigned a, b;
      do_reset();
      launched = 0; k = 0;
      while (r_idx.size() < NJOB && k < 40000) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && launched < NJOB && $urandom_range(0, 3) == 0) begin
               a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
               b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
               set_op(i, a, b); req_valid[i] = 1'b1; launched++;
            end
         end
         step(); k++;
      end
      repeat (3) step();
      checks++; if (r_idx.size() != NJOB || g_idx.size() != NJOB) begin errors++; $display("FAIL rand_count: got %0d grants %0d rsps want %0d", g_idx.size(), r_idx.size(), NJOB); end
      mptr = 0; nstart = 0;
      for (int j = 0; j < g_idx.size() && j < r_idx.size(); j++) begin
         exp = model_pick(g_mask[j], mptr);
         checks++; if (g_idx[j] != exp) begin errors++; $display("FAIL rand_pick%0d: got req%0d want req%0d", j, g_idx[j], exp); end
         checks++; if (r_idx[j] != g_idx[j] || r_val[j] != g_exp[j] || r_err[j] != 0) begin errors++; $display("FAIL rand_rsp%0d: got req%0d val %0d err %0d want req%0d val %0d err 0", j, r_idx[j], r_val[j], r_err[j], g_idx[j], g_exp[j]); end
         checks++; if (g_oa[j] != g_ea[j] || g_ob[j] != g_eb[j]) begin errors++; $display("FAIL rand_ops%0d: got %0d,%0d want %0d,%0d", j, g_oa[j], g_ob[j], g_ea[j], g_eb[j]); end
         if (g_ea[j] == 0 || g_eb[j] == 0) begin
            checks++; if (r_cyc[j] - g_cyc[j] != 1) begin errors++; $display("FAIL rand_bypass%0d: got latency %0d want 1", j, r_cyc[j] - g_cyc[j]); end
         end else nstart++;
         mptr = (r_idx[j] + 1) % NREQ;
      end
      checks++; if (st_cyc.size() != nstart) begin errors++; $display("FAIL rand_starts: got %0d want %0d", st_cyc.size(), nstart); end
      checks++; if (multi_ready != 0 || multi_rsp != 0) begin errors++; $display("FAIL rand_onehot: got %0d/%0d want 0/0", multi_ready, multi_rsp); end
   endtask

`ifdef GCD_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      do_reset();
      mute = 1'b1;
      set_op(0, 100, 15); req_valid[0] = 1'b1;
      run_until(1, 200, ok);
      checks++; if (!ok || r_err[0] != 1 || r_val[0] != 0) begin errors++; $display("FAIL tmo_rsp: got err %0d val %0d want 1 0", r_err[0], r_val[0]); end
      checks++; if (!ok || st_cyc.size() != 1 || r_cyc[0] - st_cyc[0] != TIMEOUT + 2) begin errors++; $display("FAIL tmo_len: got %0d want %0d", r_cyc[0] - st_cyc[0], TIMEOUT + 2); end
      mute = 1'b0;
      repeat (5) step();
      set_op(1, 50, 25); req_valid[1] = 1'b1;
      run_until(2, 500, ok);
      checks++; if (!ok || r_idx[1] != 1 || r_val[1] != 25 || r_err[1] != 0) begin errors++; $display("FAIL tmo_next: got req%0d val %0d err %0d want req1 25 0", r_idx[1], r_val[1], r_err[1]); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_zero_bypass();
      test_all_hold();
      test_reset_mid();
      test_random();
`ifdef GCD_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
